// File: rtl/plug_config_ctrl.sv
// plug_config_ctrl
// Plugboard configuration controller. It collects letters one at a time and
// pairs them. Before a pair is committed, each letter is checked against every
// stored slot, one slot per cycle. Illegal requests are rejected with a
// one-cycle ERR pulse.
// Slots fill in order and can only be removed all together (CLEAR).
// Every output is driven straight from a flop.
module plug_config_ctrl #(
  parameter int PAIRS = 10,
  parameter int W     = 5
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [W-1:0]           LET_IN,
  input  logic                   LET_VALID,
  input  logic                   CLEAR,
  output logic [2*W*PAIRS-1:0]   PAIRS_OUT,
  output logic [PAIRS-1:0]       ACTIVE,
  output logic [3:0]             COUNT,
  output logic                   BUSY,
  output logic                   PENDING,
  output logic                   DONE,
  output logic                   ERR
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN1  = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_SCAN2  = 3'd3,
    ST_COMMIT = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  // Highest legal letter code ('Z').
  localparam logic [W-1:0] MAX_CODE = W'(25);
  localparam logic [3:0]   LAST_IDX = 4'(PAIRS - 1);
  localparam logic [3:0]   FULL_CNT = 4'(PAIRS);

  // Returns 1 when the letter code is inside the alphabet.
  function automatic logic code_ok(input logic [W-1:0] code);
    return (code <= MAX_CODE);
  endfunction

  state_t           state_r, state_s;
  logic [W-1:0]     first_r, first_s;
  logic [W-1:0]     second_r, second_s;
  logic [3:0]       idx_r, idx_s;
  logic [W-1:0]     slot_a_r [PAIRS];
  logic [W-1:0]     slot_b_r [PAIRS];
  logic [PAIRS-1:0] active_r;
  logic [3:0]       count_r;
  logic             busy_r, pending_r, done_r, err_r;
  logic             busy_s, pending_s, done_s, err_s;
  logic [W-1:0]     cand_s;
  logic             hit_s;
  logic             commit_s;

  // Letter currently being scanned: SECOND during SCAN2, FIRST otherwise.
  always_comb begin
    cand_s = first_r;
    if (state_r == ST_SCAN2) begin
      cand_s = second_r;
    end else begin
      cand_s = first_r;
    end
  end

  // Slot comparator: an inactive slot can never produce a hit.
  always_comb begin
    hit_s = active_r[idx_r] &&
            ((slot_a_r[idx_r] == cand_s) || (slot_b_r[idx_r] == cand_s));
  end

  // Next-state and datapath-control logic. CLEAR overrides every transition.
  always_comb begin
    state_s  = state_r;
    first_s  = first_r;
    second_s = second_r;
    idx_s    = idx_r;
    commit_s = 1'b0;
    if (CLEAR) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (LET_VALID) begin
            if (!code_ok(LET_IN) || (count_r == FULL_CNT)) begin
              state_s = ST_ERR;
            end else begin
              first_s = LET_IN;
              idx_s   = 4'd0;
              state_s = ST_SCAN1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SCAN1: begin
          if (hit_s) begin
            state_s = ST_ERR;
          end else if (idx_r == LAST_IDX) begin
            idx_s   = 4'd0;
            state_s = ST_WAIT2;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end
        ST_WAIT2: begin
          if (LET_VALID) begin
            if (!code_ok(LET_IN) || (LET_IN == first_r)) begin
              state_s = ST_ERR;
            end else begin
              second_s = LET_IN;
              idx_s    = 4'd0;
              state_s  = ST_SCAN2;
            end
          end else begin
            state_s = ST_WAIT2;
          end
        end
        ST_SCAN2: begin
          if (hit_s) begin
            state_s = ST_ERR;
          end else if (idx_r == LAST_IDX) begin
            idx_s   = 4'd0;
            state_s = ST_COMMIT;
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end
        ST_COMMIT: begin
          commit_s = 1'b1;
          state_s  = ST_IDLE;
        end
        ST_ERR: begin
          first_s = '0;
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they can be registered.
  always_comb begin
    busy_s    = 1'b0;
    pending_s = 1'b0;
    done_s    = 1'b0;
    err_s     = 1'b0;
    case (state_s)
      ST_IDLE:   busy_s = 1'b0;
      ST_SCAN1:  busy_s = 1'b1;
      ST_WAIT2:  pending_s = 1'b1;
      ST_SCAN2:  busy_s = 1'b1;
      ST_COMMIT: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      ST_ERR: begin
        busy_s = 1'b1;
        err_s  = 1'b1;
      end
      default:   busy_s = 1'b0;
    endcase
  end

  // FSM state, letter latches, scan index and registered status flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      first_r   <= '0;
      second_r  <= '0;
      idx_r     <= 4'd0;
      busy_r    <= 1'b0;
      pending_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      first_r   <= first_s;
      second_r  <= second_s;
      idx_r     <= idx_s;
      busy_r    <= busy_s;
      pending_r <= pending_s;
      done_r    <= done_s;
      err_r     <= err_s;
    end
  end

  // Slot register file: appended at COMMIT, wiped by reset or CLEAR.
  always_ff @(posedge CLK) begin
    if (!RST_N || CLEAR) begin
      for (int i = 0; i < PAIRS; i++) begin
        slot_a_r[i] <= '0;
        slot_b_r[i] <= '0;
      end
      active_r <= '0;
      count_r  <= 4'd0;
    end else if (commit_s) begin
      for (int i = 0; i < PAIRS; i++) begin
        if (count_r == 4'(i)) begin
          slot_a_r[i] <= first_r;
          slot_b_r[i] <= second_r;
          active_r[i] <= 1'b1;
        end
      end
      count_r <= count_r + 4'd1;
    end
  end

  // Flatten slots onto the pair bus: first letter in the upper half.
  for (genvar g = 0; g < PAIRS; g++) begin : g_pairs
    assign PAIRS_OUT[2*W*g +: 2*W] = {slot_a_r[g], slot_b_r[g]};
  end

  assign ACTIVE  = active_r;
  assign COUNT   = count_r;
  assign BUSY    = busy_r;
  assign PENDING = pending_r;
  assign DONE    = done_r;
  assign ERR     = err_r;

endmodule

// File: tb/tb_plug_config_ctrl.sv
// Directed testbench for plug_config_ctrl.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_plug_config_ctrl;
  localparam int PAIRS = 10;
  localparam int W     = 5;

  logic                 CLK = 1'b0;
  logic                 RST_N;
  logic [W-1:0]         LET_IN;
  logic                 LET_VALID;
  logic                 CLEAR;
  logic [2*W*PAIRS-1:0] PAIRS_OUT;
  logic [PAIRS-1:0]     ACTIVE;
  logic [3:0]           COUNT;
  logic                 BUSY, PENDING, DONE, ERR;

  int total = 0;
  int bad   = 0;
  int err_seen  = 0;
  int done_seen = 0;
  int e0, d0;

  plug_config_ctrl #(.PAIRS(PAIRS), .W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .LET_IN(LET_IN), .LET_VALID(LET_VALID),
    .CLEAR(CLEAR), .PAIRS_OUT(PAIRS_OUT), .ACTIVE(ACTIVE), .COUNT(COUNT),
    .BUSY(BUSY), .PENDING(PENDING), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Pulse counters sampled on the falling edge
  always @(negedge CLK) begin
    if (ERR === 1'b1) err_seen++;
    if (DONE === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a letter for exactly one sampling edge; returns in the cycle after it
  task automatic enter(input logic [W-1:0] code);
    LET_IN = code;
    LET_VALID = 1'b1;
    tick();
    LET_VALID = 1'b0;
  endtask

  task automatic commit_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    enter(a);
    tick_n(PAIRS);
    enter(b);
    tick_n(PAIRS + 1);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CLEAR = 1'b0; LET_VALID = 1'b0; LET_IN = '0;
    tick_n(2);
    total++; if (PAIRS_OUT !== '0) begin bad++; $display("FAIL reset_pairs_out: got %h want 0", PAIRS_OUT); end
    total++; if ({ACTIVE, COUNT} !== 14'd0) begin bad++; $display("FAIL reset_active_count: got %h/%0d want 0/0", ACTIVE, COUNT); end
    total++; if ({BUSY, PENDING, DONE, ERR} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {BUSY, PENDING, DONE, ERR}); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_first_pair();
    e0 = err_seen;
    enter(5'd0);
    total++; if ({BUSY, PENDING} !== 2'b10) begin bad++; $display("FAIL scan1_start: got busy/pend %b want 10", {BUSY, PENDING}); end
    tick_n(PAIRS - 1);
    total++; if ({BUSY, PENDING} !== 2'b10) begin bad++; $display("FAIL scan1_last: got busy/pend %b want 10", {BUSY, PENDING}); end
    tick();
    total++; if ({BUSY, PENDING} !== 2'b01) begin bad++; $display("FAIL wait2_entry: got busy/pend %b want 01", {BUSY, PENDING}); end
    tick_n(2);
    total++; if (PENDING !== 1'b1) begin bad++; $display("FAIL wait2_hold: got %b want 1", PENDING); end
    enter(5'd1);
    tick_n(PAIRS - 1);
    total++; if ({DONE, BUSY} !== 2'b01) begin bad++; $display("FAIL scan2_last: got done/busy %b want 01", {DONE, BUSY}); end
    tick();
    total++; if ({DONE, COUNT} !== {1'b1, 4'd0}) begin bad++; $display("FAIL done_cycle: got done=%b count=%0d want done=1 count=0", DONE, COUNT); end
    tick();
    total++; if (PAIRS_OUT[9:0] !== 10'b00000_00001) begin bad++; $display("FAIL slot0_ab: got %b want 0000000001", PAIRS_OUT[9:0]); end
    total++; if ({ACTIVE, COUNT} !== {10'b1, 4'd1}) begin bad++; $display("FAIL ab_active_count: got %b/%0d want 1/1", ACTIVE, COUNT); end
    total++; if ({DONE, BUSY} !== 2'b00) begin bad++; $display("FAIL after_commit_idle: got done/busy %b want 00", {DONE, BUSY}); end
    total++; if (err_seen !== e0) begin bad++; $display("FAIL ab_no_err: got %0d errs want 0", err_seen - e0); end
  endtask

  task automatic test_scan_conflict();
    e0 = err_seen;
    enter(5'd2);
    tick_n(PAIRS);
    total++; if (PENDING !== 1'b1) begin bad++; $display("FAIL c_pending: got %b want 1", PENDING); end
    enter(5'd0);
    total++; if ({ERR, BUSY} !== 2'b01) begin bad++; $display("FAIL scan2_slot0: got err/busy %b want 01", {ERR, BUSY}); end
    tick();
    total++; if ({ERR, PENDING} !== 2'b10) begin bad++; $display("FAIL scan2_hit_err: got err/pend %b want 10", {ERR, PENDING}); end
    tick();
    total++; if ({ERR, BUSY, ACTIVE, COUNT} !== {2'b00, 10'b1, 4'd1}) begin bad++; $display("FAIL after_scan2_err: got err/busy %b active %b count %0d", {ERR, BUSY}, ACTIVE, COUNT); end
    enter(5'd1);
    tick();
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL scan1_hit_err: got %b want 1", ERR); end
    tick();
    total++; if ({err_seen - e0, 4'(COUNT)} !== {32'd2, 4'd1}) begin bad++; $display("FAIL conflict_summary: got errs=%0d count=%0d want 2/1", err_seen - e0, COUNT); end
  endtask

  task automatic test_bad_codes();
    e0 = err_seen;
    enter(5'd3);
    tick_n(PAIRS);
    enter(5'd3);
    total++; if ({ERR, PENDING} !== 2'b10) begin bad++; $display("FAIL self_pair_err: got err/pend %b want 10", {ERR, PENDING}); end
    tick();
    enter(5'd27);
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL code27_err: got %b want 1", ERR); end
    tick();
    enter(5'd26);
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL code26_err: got %b want 1", ERR); end
    tick();
    total++; if ({ERR, BUSY, COUNT} !== {2'b00, 4'd1} || err_seen - e0 != 3) begin bad++; $display("FAIL bad_codes_summary: got err/busy %b count %0d errs %0d want 00/1/3", {ERR, BUSY}, COUNT, err_seen - e0); end
  endtask

  task automatic test_fill_board();
    e0 = err_seen; d0 = done_seen;
    for (int i = 1; i < PAIRS; i++) commit_pair(5'(2 * i), 5'(2 * i + 1));
    total++; if ({ACTIVE, COUNT} !== {10'h3FF, 4'd10}) begin bad++; $display("FAIL full_active_count: got %h/%0d want 3ff/10", ACTIVE, COUNT); end
    total++; if (done_seen - d0 != 9 || err_seen != e0) begin bad++; $display("FAIL fill_pulses: got done=%0d err=%0d want 9/0", done_seen - d0, err_seen - e0); end
    total++; if (PAIRS_OUT[99:90] !== {5'd18, 5'd19}) begin bad++; $display("FAIL slot9_st: got %b want 1001010011", PAIRS_OUT[99:90]); end
    total++; if (PAIRS_OUT[49:40] !== {5'd8, 5'd9}) begin bad++; $display("FAIL slot4_ij: got %b want 0100001001", PAIRS_OUT[49:40]); end
    enter(5'd20);
    total++; if ({ERR, BUSY} !== 2'b11) begin bad++; $display("FAIL full_err: got err/busy %b want 11", {ERR, BUSY}); end
    tick();
    total++; if ({ACTIVE, COUNT, PENDING, BUSY} !== {10'h3FF, 4'd10, 2'b00}) begin bad++; $display("FAIL full_unchanged: got %h/%0d pend/busy %b", ACTIVE, COUNT, {PENDING, BUSY}); end
  endtask

  task automatic test_clear_and_drop();
    e0 = err_seen; d0 = done_seen;
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    total++; if ({ACTIVE, COUNT} !== 14'd0 || PAIRS_OUT !== '0) begin bad++; $display("FAIL clear_idle: got %h/%0d bus %h want 0", ACTIVE, COUNT, PAIRS_OUT); end
    enter(5'd0);
    tick_n(3);
    LET_IN = 5'd7; LET_VALID = 1'b1;
    tick();
    LET_VALID = 1'b0;
    tick_n(PAIRS - 5);
    total++; if ({BUSY, PENDING, ERR} !== 3'b100) begin bad++; $display("FAIL busy_drop_scan: got busy/pend/err %b want 100", {BUSY, PENDING, ERR}); end
    tick();
    total++; if (PENDING !== 1'b1) begin bad++; $display("FAIL busy_drop_wait2: got %b want 1", PENDING); end
    CLEAR = 1'b1; LET_IN = 5'd1; LET_VALID = 1'b1;
    tick();
    CLEAR = 1'b0; LET_VALID = 1'b0;
    total++; if ({PENDING, BUSY, ACTIVE, COUNT} !== 16'd0) begin bad++; $display("FAIL clear_wait2: got pend/busy %b active %h count %0d want 0", {PENDING, BUSY}, ACTIVE, COUNT); end
    tick();
    total++; if (err_seen != e0 || done_seen != d0 || BUSY !== 1'b0) begin bad++; $display("FAIL clear_no_pulse: got err=%0d done=%0d busy=%b want 0/0/0", err_seen - e0, done_seen - d0, BUSY); end
  endtask

  task automatic test_reset_mid_scan();
    commit_pair(5'd0, 5'd1);
    total++; if (COUNT !== 4'd1) begin bad++; $display("FAIL pre_reset_count: got %0d want 1", COUNT); end
    enter(5'd2);
    tick_n(PAIRS);
    enter(5'd3);
    tick_n(3);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL in_scan2: got %b want 1", BUSY); end
    RST_N = 1'b0;
    tick();
    total++; if (PAIRS_OUT !== '0 || {ACTIVE, COUNT} !== 14'd0) begin bad++; $display("FAIL midreset_state: got %h/%0d bus %h want 0", ACTIVE, COUNT, PAIRS_OUT); end
    total++; if ({BUSY, PENDING, DONE, ERR} !== 4'b0000) begin bad++; $display("FAIL midreset_flags: got %b want 0000", {BUSY, PENDING, DONE, ERR}); end
    RST_N = 1'b1;
    tick();
    commit_pair(5'd4, 5'd5);
    total++; if (PAIRS_OUT[9:0] !== {5'd4, 5'd5}) begin bad++; $display("FAIL fresh_slot0: got %b want 0010000101", PAIRS_OUT[9:0]); end
    total++; if ({ACTIVE, COUNT} !== {10'b1, 4'd1}) begin bad++; $display("FAIL fresh_count: got %b/%0d want 1/1", ACTIVE, COUNT); end
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_scan_conflict();
    test_bad_codes();
    test_fill_board();
    test_clear_and_drop();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plug_config_ctrl.md
# plug_config_ctrl

Sequential configuration controller for the plugboard. Accepts letters one at a time from the keyboard/UI path, pairs them, and rejects illegal pairs: out-of-range code, self-pair, letter already plugged, or board full. It scans the stored pairs one slot per cycle, commits legal pairs into a slot register file, and drives the flattened pair bus and per-pair active bits consumed by the array of plugboard pair comparators.

## Interface
Parameters:
- PAIRS, 10: number of plug slots (1..15).
- W, 5: letter code width; legal codes are 0..25 ('A'=0).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  synchronous reset, active-low. One clock; reset is synchronous and active-low.
- LET_IN  in  W  letter code, sampled when LET_VALID=1.
- LET_VALID  in  1  single-cycle strobe qualifying LET_IN.
- CLEAR  in  1  single-cycle strobe; removes all pairs.
- PAIRS_OUT  out  2*W*PAIRS  slot i occupies bits [10i+9:10i]. First letter is in [10i+9:10i+5], second letter is in [10i+4:10i].
- ACTIVE  out  PAIRS  bit i=1 when slot i holds a committed pair.
- COUNT  out  4  number of committed pairs.
- BUSY  out  1  high in SCAN1, SCAN2, COMMIT and ERR; LET_VALID is ignored while high.
- PENDING  out  1  high in WAIT2 (first letter held).
- DONE  out  1  single-cycle pulse, pair committed.
- ERR  out  1  single-cycle pulse, request rejected.

## Operation
- States: IDLE, SCAN1, WAIT2, SCAN2, COMMIT, ERR.
- IDLE behaviour on LET_VALID:
  - LET_IN>25 or COUNT==PAIRS -> ERR.
  - Otherwise latch FIRST=LET_IN, set idx=0 -> SCAN1.
- SCAN1: each cycle compare FIRST against both halves of slot idx, gated by ACTIVE[idx].
  - Match -> ERR.
  - Else if idx==PAIRS-1 -> WAIT2.
  - Else idx++.
  - The scan always covers all PAIRS slots; inactive slots never match.
- WAIT2 behaviour on LET_VALID:
  - LET_IN>25 or LET_IN==FIRST -> ERR.
  - Otherwise latch SECOND, idx=0 -> SCAN2.
  - With no LET_VALID, hold indefinitely.
- SCAN2: same scan as SCAN1 using SECOND. Completion goes to COMMIT.
- COMMIT:
  - DONE=1.
  - At the closing edge write slot[COUNT]={FIRST,SECOND}, set ACTIVE[COUNT]=1, COUNT++.
  - Go to IDLE.
- ERR: ERR=1 for exactly one cycle, FIRST discarded, -> IDLE.
- Slots fill in order 0,1,2,…; no individual removal.
- CLEAR has priority over all FSM activity except reset.
  - When sampled it sets PAIRS_OUT=0, ACTIVE=0, COUNT=0, FSM=IDLE.
  - It aborts any scan or pending letter without asserting ERR or DONE.
  - A LET_VALID coincident with CLEAR is dropped.
- LET_VALID arriving while BUSY=1 is dropped silently; no ERR.

## Timing
- Reset values: PAIRS_OUT=0, ACTIVE=0, COUNT=0, BUSY=0, PENDING=0, DONE=0, ERR=0, state IDLE.
- First letter sampled at edge 0: SCAN1 occupies cycles 1..PAIRS. PENDING=1 from cycle PAIRS+1.
- Second letter sampled at edge k:
  - SCAN2 occupies cycles k+1..k+PAIRS.
  - DONE=1 in cycle k+PAIRS+1.
  - New PAIRS_OUT/ACTIVE/COUNT are visible from cycle k+PAIRS+2.
- Conflict found in a scan cycle aborts early: ERR=1 in the next cycle.
- Invalid code, self-pair or full board: ERR=1 in the cycle after sampling.
- Outputs are registered; no combinational path from inputs to outputs.
- RST_N low mid-operation returns all outputs to reset values at the next edge.

## Test plan
- Reset, then LET_IN=0 ('A'), later LET_IN=1 ('B'), PAIRS=10: DONE in cycle k+11. Afterwards PAIRS_OUT[9:0]=10'b00000_00001, ACTIVE=10'b1, COUNT=1, ERR never asserted.
- With A–B committed, enter 'C' then 'A': SCAN2 hits slot 0 -> ERR pulse, ACTIVE/COUNT unchanged, PENDING=0. Enter 'B' as the first letter -> ERR during SCAN1.
- Enter 'D' then 'D' -> ERR the cycle after the second sample. Enter LET_IN=27 in IDLE -> ERR the next cycle.
- Commit 10 disjoint pairs (A–B … S–T): COUNT=10, ACTIVE=10'h3FF. Eleventh letter 'U' -> ERR, no state change.
- Pulse LET_VALID during SCAN1 -> ignored, no ERR. Assert CLEAR in WAIT2 -> next cycle ACTIVE=0, COUNT=0, PENDING=0, no ERR/DONE.
- Drop RST_N during SCAN2 -> next cycle all outputs at reset values. A fresh pair then commits to slot 0.
